rr_grant_scheduler: RTL

//  Round-robin scheduler that shares one resource among 16 requesters.

---
 rtl/rr_grant_scheduler.sv | 102 ++++++++++
 1 files changed

// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler for 16 requesters with a tenure watchdog.
// One idle bubble separates every handover so the resource mux can turn around.
module rr_grant_scheduler #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] REQ,
  input  logic        RELEASE,
  output logic [15:0] GNT,
  output logic [3:0]  GNT_IDX,
  output logic        GNT_VALID,
  output logic        TIMEOUT
);

  localparam int unsigned N     = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_d;
  logic               valid_d;
  logic               timeout_d;
  logic [N-1:0]       gnt_d;
  logic [IDX_W-1:0]   win;

  // Circular priority search starting at ptr; descending loop lets the nearest bit win.
  always_comb begin
    win = ptr_q;
    for (int i = N - 1; i >= 0; i--) begin
      if (REQ[ptr_q + IDX_W'(i)]) begin
        win = ptr_q + IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    idx_d     = GNT_IDX;
    valid_d   = GNT_VALID;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|REQ) begin
          idx_d   = win;
          valid_d = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Release or withdrawal takes precedence over the watchdog.
        if (RELEASE || !REQ[GNT_IDX]) begin
          valid_d = 1'b0;
          ptr_d   = GNT_IDX + IDX_W'(1);
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(MAX_HOLD)) begin
          valid_d   = 1'b0;
          timeout_d = 1'b1;
          ptr_d     = GNT_IDX + IDX_W'(1);
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    gnt_d = valid_d ? (N'(1) << idx_d) : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      GNT_IDX   <= '0;
      GNT_VALID <= 1'b0;
      TIMEOUT   <= 1'b0;
      GNT       <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      GNT_IDX   <= idx_d;
      GNT_VALID <= valid_d;
      TIMEOUT   <= timeout_d;
      GNT       <= gnt_d;
    end
  end

endmodule
